// File: rtl/seq_detect_ctrl.sv
// Run-controlled programmable serial pattern detector with match counting.
// A run latches its configuration at start and reports match pulses, a saturating count and a done flag.
module seq_detect_ctrl #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 5,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               aresetn,
    input  logic               start,
    input  logic               abort,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic [CNT_W-1:0]   cfg_target,
    input  logic               x,
    input  logic               x_valid,
    output logic               z,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   match_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [MAX_LEN-1:0] r_pat;
    logic [LEN_W-1:0]   r_len;
    logic               r_ovl;
    logic [CNT_W-1:0]   r_target;
    logic [MAX_LEN-1:0] r_hist;
    logic [LEN_W-1:0]   r_bits_seen;
    logic [CNT_W-1:0]   r_count;
    logic               r_z;
    logic               r_busy;
    logic               r_done;

    state_t             w_state_nxt;
    logic [MAX_LEN-1:0] w_pat_nxt;
    logic [LEN_W-1:0]   w_len_nxt;
    logic               w_ovl_nxt;
    logic [CNT_W-1:0]   w_target_nxt;
    logic [MAX_LEN-1:0] w_hist_nxt;
    logic [LEN_W-1:0]   w_bits_nxt;
    logic [CNT_W-1:0]   w_count_nxt;
    logic               w_z_nxt;
    logic               w_done_nxt;

    logic [MAX_LEN-1:0] w_hist_shift;
    logic [MAX_LEN-1:0] w_mask;
    logic [LEN_W-1:0]   w_len_clamp;
    logic [LEN_W-1:0]   w_bits_inc;
    logic [CNT_W-1:0]   w_count_inc;
    logic               w_len_ok;
    logic               w_pat_eq;
    logic               w_match;

    // Pattern compare datapath: mask selects the low r_len bits of the shifted history.
    always_comb begin
        w_hist_shift = {r_hist[MAX_LEN-2:0], x};
        w_mask       = {MAX_LEN{1'b0}};
        for (int i = 0; i < MAX_LEN; i++) begin
            w_mask[i] = (LEN_W'(i) < r_len);
        end
        w_len_ok    = (({1'b0, r_bits_seen} + {{LEN_W{1'b0}}, 1'b1}) >= {1'b0, r_len});
        w_pat_eq    = (((w_hist_shift ^ r_pat) & w_mask) == {MAX_LEN{1'b0}});
        w_match     = w_len_ok && w_pat_eq;
        w_bits_inc  = (r_bits_seen < r_len) ? (r_bits_seen + LEN_W'(1)) : r_bits_seen;
        w_count_inc = (r_count == {CNT_W{1'b1}}) ? r_count : (r_count + CNT_W'(1));
    end

    // Length clamp applied when the configuration is latched.
    always_comb begin
        if (cfg_len == {LEN_W{1'b0}}) begin
            w_len_clamp = LEN_W'(1);
        end else if (cfg_len > LEN_W'(MAX_LEN)) begin
            w_len_clamp = LEN_W'(MAX_LEN);
        end else begin
            w_len_clamp = cfg_len;
        end
    end

    // Next-state and next-output logic of the run FSM.
    always_comb begin
        w_state_nxt  = r_state;
        w_pat_nxt    = r_pat;
        w_len_nxt    = r_len;
        w_ovl_nxt    = r_ovl;
        w_target_nxt = r_target;
        w_hist_nxt   = r_hist;
        w_bits_nxt   = r_bits_seen;
        w_count_nxt  = r_count;
        w_z_nxt      = 1'b0;
        w_done_nxt   = r_done;
        case (r_state)
            ST_RUN: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (x_valid) begin
                    w_hist_nxt = w_hist_shift;
                    if (w_match) begin
                        w_z_nxt     = 1'b1;
                        w_count_nxt = w_count_inc;
                        // Non-overlap mode: the completing bit may not seed the next match.
                        if (r_ovl) begin
                            w_bits_nxt = w_bits_inc;
                        end else begin
                            w_bits_nxt = {LEN_W{1'b0}};
                        end
                        if ((r_target != {CNT_W{1'b0}}) && (w_count_inc == r_target)) begin
                            w_state_nxt = ST_DONE;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_state_nxt = ST_RUN;
                        end
                    end else begin
                        w_bits_nxt = w_bits_inc;
                    end
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_IDLE, ST_DONE: begin
                if (start && !abort) begin
                    w_state_nxt  = ST_RUN;
                    w_pat_nxt    = cfg_pattern;
                    w_len_nxt    = w_len_clamp;
                    w_ovl_nxt    = cfg_overlap;
                    w_target_nxt = cfg_target;
                    w_hist_nxt   = {MAX_LEN{1'b0}};
                    w_bits_nxt   = {LEN_W{1'b0}};
                    w_count_nxt  = {CNT_W{1'b0}};
                    w_done_nxt   = 1'b0;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, shadow configuration and registered outputs.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state     <= ST_IDLE;
            r_pat       <= {MAX_LEN{1'b0}};
            r_len       <= LEN_W'(1);
            r_ovl       <= 1'b0;
            r_target    <= {CNT_W{1'b0}};
            r_hist      <= {MAX_LEN{1'b0}};
            r_bits_seen <= {LEN_W{1'b0}};
            r_count     <= {CNT_W{1'b0}};
            r_z         <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pat       <= w_pat_nxt;
            r_len       <= w_len_nxt;
            r_ovl       <= w_ovl_nxt;
            r_target    <= w_target_nxt;
            r_hist      <= w_hist_nxt;
            r_bits_seen <= w_bits_nxt;
            r_count     <= w_count_nxt;
            r_z         <= w_z_nxt;
            r_busy      <= (w_state_nxt == ST_RUN);
            r_done      <= w_done_nxt;
        end
    end

    assign z           = r_z;
    assign busy        = r_busy;
    assign done        = r_done;
    assign match_count = r_count;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Self-checking bench for seq_detect_ctrl: a queue-based reference model compared every cycle,
// plus literal expectations for each directed scenario.
module tb_seq_detect_ctrl;

    logic       clk = 1'b0;
    logic       aresetn = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] cfg_pattern = 8'd0;
    logic [4:0] cfg_len = 5'd0;
    logic       cfg_overlap = 1'b0;
    logic [7:0] cfg_target = 8'd0;
    logic       x = 1'b0;
    logic       x_valid = 1'b0;
    logic       z;
    logic       busy;
    logic       done;
    logic [7:0] match_count;

    int checks = 0;
    int failures = 0;

    seq_detect_ctrl #(.MAX_LEN(8), .LEN_W(5), .CNT_W(8)) u_dut (
        .clk(clk), .aresetn(aresetn), .start(start), .abort(abort),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .cfg_target(cfg_target), .x(x), .x_valid(x_valid),
        .z(z), .busy(busy), .done(done), .match_count(match_count)
    );

    always #5 clk = ~clk;

    // Reference model: bits received since the last clear, newest at the back.
    int       m_state = 0;   // 0 idle, 1 run, 2 done
    int       m_count = 0;
    int       m_zp = 0;
    bit       m_z = 1'b0;
    bit       m_done = 1'b0;
    bit [7:0] m_pat = 8'd0;
    int       m_len = 1;
    bit       m_ovl = 1'b0;
    int       m_tgt = 0;
    bit       q[$];

    function automatic bit tail_match();
        if (q.size() < m_len) return 1'b0;
        for (int k = 0; k < m_len; k++) begin
            if (q[q.size() - 1 - k] != m_pat[k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_update();
        if (!aresetn) begin
            m_state = 0; m_count = 0; m_z = 1'b0; m_done = 1'b0; q.delete();
        end else begin
            m_z = 1'b0;
            if (m_state == 1) begin
                if (abort) begin
                    m_state = 0;
                end else if (x_valid) begin
                    q.push_back(x);
                    if (q.size() > 32) void'(q.pop_front());
                    if (tail_match()) begin
                        m_z = 1'b1;
                        m_zp++;
                        if (m_count < 255) m_count++;
                        if (!m_ovl) q.delete();
                        if (m_tgt != 0 && m_count == m_tgt) begin
                            m_state = 2;
                            m_done = 1'b1;
                        end
                    end
                end
            end else if (start && !abort) begin
                m_pat = cfg_pattern;
                m_len = (cfg_len == 0) ? 1 : ((cfg_len > 8) ? 8 : int'(cfg_len));
                m_ovl = cfg_overlap;
                m_tgt = cfg_target;
                q.delete();
                m_count = 0; m_done = 1'b0; m_zp = 0;
                m_state = 1;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge aresetn);
            model_update();
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("z", z, m_z);
            chk("busy", busy, (m_state == 1) ? 1 : 0);
            chk("done", done, m_done);
            chk("match_count", match_count, m_count);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic start_run(input logic [7:0] pat, input logic [4:0] len,
                             input logic ovl, input logic [7:0] tgt);
        cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl; cfg_target = tgt;
        start = 1'b1;
        step();
        start = 1'b0;
        cfg_pattern = 8'($urandom); cfg_len = 5'($urandom); cfg_overlap = 1'($urandom);
        cfg_target = 8'($urandom_range(1, 3));
    endtask

    task automatic send(input logic b);
        x = b; x_valid = 1'b1;
        step();
        x_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            x = ~x;
            step();
        end
    endtask

    task automatic do_abort();
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask

    logic [4:0] bits101;

    initial begin
        bits101 = 5'b10101;
        #23;
        chk("reset_z", z, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_count", match_count, 0);
        aresetn = 1'b1;
        step();

        // Overlapping 101 on 10101
        start_run(8'b101, 5'd3, 1'b1, 8'd0);
        for (int i = 4; i >= 0; i--) send(bits101[i]);
        idle(2);
        chk("s1_count", match_count, 2);
        chk("s1_busy", busy, 1);
        chk("s1_model_pulses", m_zp, 2);
        do_abort();

        // Non-overlapping 101 on 10101
        start_run(8'b101, 5'd3, 1'b0, 8'd0);
        for (int i = 4; i >= 0; i--) send(bits101[i]);
        idle(1);
        chk("s2_count", match_count, 1);
        chk("s2_model_pulses", m_zp, 1);
        do_abort();

        // Target 2 on 1111
        start_run(8'b11, 5'd2, 1'b1, 8'd2);
        send(1'b1); send(1'b1); send(1'b1);
        chk("s3_done", done, 1);
        chk("s3_busy", busy, 0);
        send(1'b1);
        idle(1);
        chk("s3_count", match_count, 2);
        chk("s3_done_hold", done, 1);

        // Gapped stream, with an ignored start mid-run
        start_run(8'b101, 5'd3, 1'b1, 8'd0);
        for (int i = 4; i >= 0; i--) begin
            send(bits101[i]);
            idle(i % 4);
            if (i == 2) begin
                cfg_pattern = 8'b0; cfg_len = 5'd1; start = 1'b1;
                step();
                start = 1'b0;
            end
        end
        chk("s4_count", match_count, 2);
        chk("s4_model_pulses", m_zp, 2);
        do_abort();

        // Abort on a cycle whose bit would complete the match
        start_run(8'b101, 5'd3, 1'b1, 8'd0);
        send(1'b1); send(1'b0);
        x = 1'b1; x_valid = 1'b1; abort = 1'b1;
        step();
        x_valid = 1'b0; abort = 1'b0;
        chk("s5_z", z, 0);
        chk("s5_busy", busy, 0);
        chk("s5_count", match_count, 0);
        chk("s5_done", done, 0);
        idle(2);
        chk("s5_model_pulses", m_zp, 0);

        // Start and abort together in IDLE
        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        chk("s6_busy", busy, 0);
        idle(1);

        // Length above MAX_LEN clamps to 8
        start_run(8'b10110011, 5'd20, 1'b0, 8'd0);
        for (int i = 7; i >= 0; i--) send(cfg_pattern_bit(8'b10110011, i));
        chk("s7_count", match_count, 1);
        do_abort();

        // Length 0 clamps to 1; count saturates at 255
        start_run(8'b1, 5'd0, 1'b1, 8'd0);
        for (int i = 0; i < 260; i++) send(1'b1);
        chk("s8_count", match_count, 255);
        chk("s8_z_at_sat", z, 1);
        chk("s8_model_pulses", m_zp, 260);
        do_abort();

        // Asynchronous reset mid-run
        start_run(8'b1, 5'd1, 1'b1, 8'd0);
        send(1'b1);
        chk("s9_pre_z", z, 1);
        aresetn = 1'b0;
        #1;
        chk("s9_rst_z", z, 0);
        chk("s9_rst_busy", busy, 0);
        chk("s9_rst_count", match_count, 0);
        chk("s9_rst_done", done, 0);
        idle(2);
        aresetn = 1'b1;
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    function automatic logic cfg_pattern_bit(input logic [7:0] p, input int i);
        return p[i];
    endfunction

endmodule

// File: doc/seq_detect_ctrl.md
# seq_detect_ctrl

Run-controlled, programmable serial pattern detector with match counting. It generalises the fixed "101" detector into a configurable engine. Software or a host FSM loads a pattern, its length and an overlap mode, starts a run, and reads back match pulses, a match count and a completion flag. The block sits between the serial input stream and the control/status logic that schedules detection runs.

## Interface
- MAX_LEN, 8: maximum pattern length in bits (2..16)
- LEN_W, 5: width of cfg_len; must hold MAX_LEN
- CNT_W, 8: width of the match counter

- clk  in  1  rising-edge clock
- aresetn  in  1  asynchronous active-low reset
- start  in  1  single-cycle run request
- abort  in  1  single-cycle run cancel
- cfg_pattern  in  MAX_LEN  pattern; bit [len-1] is the first bit received, bit [0] the last
- cfg_len  in  LEN_W  pattern length in bits
- cfg_overlap  in  1  1 = overlapping matches allowed, 0 = history cleared after each match
- cfg_target  in  CNT_W  stop after this many matches; 0 = run until abort
- x  in  1  serial data bit
- x_valid  in  1  x is sampled this cycle
- z  out  1  one-cycle match pulse (registered)
- busy  out  1  run in progress
- done  out  1  target reached; held until next start
- match_count  out  CNT_W  matches in current/last run

## Operation
- FSM states: IDLE, RUN, DONE.
- Reset: state = IDLE. z, busy and done are 0. match_count and the history register are 0.
- IDLE or DONE, start=1: the block latches cfg_pattern, cfg_len, cfg_overlap and cfg_target into shadow registers. It clears history, bits_seen, match_count and done, then moves to RUN.
- Length clamp at latch: 0 becomes 1; values above MAX_LEN become MAX_LEN.
- Config inputs are ignored outside the start cycle. Changing them mid-run has no effect.
- RUN, x_valid=1:
  - hist ← {hist, x}, with the newest bit in the LSB.
  - bits_seen increments and saturates at len.
- Match condition: (bits_seen+1 ≥ len) and the low len bits of {hist,x} equal the low len bits of the pattern.
- On a match:
  - z=1 for the next cycle.
  - match_count increments, saturating at 2^CNT_W−1; z still pulses when saturated.
  - If cfg_overlap=0, bits_seen is cleared, so the current bit cannot begin the next match.
- Target reached: if cfg_target≠0 and the updated count equals cfg_target, the FSM goes to DONE with done=1 and busy=0.
- DONE: x_valid is ignored. match_count and done hold. start begins a new run.
- RUN, abort=1: the FSM returns to IDLE and busy=0. match_count holds, done stays 0, and the pending z for that cycle is suppressed.
- start during RUN is ignored. abort outside RUN is ignored. start and abort in the same cycle: abort wins, so start is ignored in RUN and IDLE/DONE are unchanged.
- busy = (state == RUN).

## Timing
- start sampled at edge t: busy=1 after t. The first bit accepted is x_valid at edge t+1. x_valid coinciding with start is dropped.
- Match latency is one cycle. If the completing bit is sampled at edge t, then z, match_count and done all update at edge t (visible in cycle t..t+1). z deasserts at edge t+1 unless another match occurs.
- The final match and done assert on the same edge. busy falls on that same edge.
- Back-to-back x_valid is supported at full rate. Gaps in x_valid do not disturb history.
- aresetn assertion mid-run clears all state immediately, independent of clk. Deassertion is synchronised externally.

## Test plan
- pattern=3'b101, len=3, overlap=1, target=0; bits 1,0,1,0,1 on consecutive cycles -> z pulses after bits 3 and 5; match_count=2; busy stays 1.
- Same stream with overlap=0 -> z only after bit 3; match_count=1.
- pattern=2'b11, len=2, overlap=1, target=2; bits 1,1,1,1 -> z after bits 2 and 3; done=1 and busy=0 on bit 3's edge; bit 4 ignored; match_count=2.
- pattern 101 with x_valid gaps of 0–3 idle cycles between bits (x toggling while invalid) -> identical results to the first scenario.
- Abort and reset:
  - Abort after bits 1,0 -> IDLE, z never pulses, count=0.
  - Start plus abort in the same cycle -> stays IDLE.
  - aresetn low mid-run -> all outputs 0 immediately.
- CNT_W=2, len=0 (clamped to 1), pattern=1, target=0; six 1s -> six z pulses; match_count saturates at 3.
